// File: rtl/aidc_lite_ahb_arbiter_if.sv
// Arbitration signal bundle between the AIDCLite bus masters and the system-bus arbiter.
// The master modport is the request side; the slave modport is the arbiter side.
interface aidc_lite_ahb_arbiter_if #(
    parameter int NUM_MST = 3
);
    localparam int IDXW = $clog2(NUM_MST);

    logic [NUM_MST-1:0] hbusreq_i;
    logic [NUM_MST-1:0] hlock_i;
    logic [1:0]         htrans_i;
    logic [2:0]         hburst_i;
    logic               hready_i;
    logic [NUM_MST-1:0] hgrant_o;
    logic [IDXW-1:0]    hmaster_o;
    logic               hmastlock_o;

    modport master (
        output hbusreq_i, hlock_i, htrans_i, hburst_i, hready_i,
        input  hgrant_o, hmaster_o, hmastlock_o
    );

    modport slave (
        input  hbusreq_i, hlock_i, htrans_i, hburst_i, hready_i,
        output hgrant_o, hmaster_o, hmastlock_o
    );
endinterface

// File: rtl/aidc_lite_ahb_arbiter.sv
// Round-robin AHB2 arbiter for the shared AIDCLite system bus; never splits fixed bursts or locked sequences.
// Define AIDC_LITE_ARB_TIMEOUT_EN to cap undefined-length INCR tenure at TIMEOUT cycles.
module aidc_lite_ahb_arbiter #(
    parameter int NUM_MST     = 3,
    parameter int DEFAULT_MST = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    aidc_lite_ahb_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(NUM_MST);

    typedef logic [IDXW-1:0]    idx_t;
    typedef logic [IDXW:0]      cand_t;
    typedef logic [NUM_MST-1:0] vec_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_OWN   = 2'd2
    } state_t;

    localparam idx_t       DEF_IDX   = idx_t'(DEFAULT_MST);
    localparam vec_t       DEF_OH    = {{(NUM_MST-1){1'b0}}, 1'b1} << DEFAULT_MST;
    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;

    if (NUM_MST < 2 || NUM_MST > 8 || DEFAULT_MST >= NUM_MST || TIMEOUT < 1) begin : g_param_chk
        $error("aidc_lite_ahb_arbiter: illegal parameter set");
    end

    function automatic logic [3:0] burst_beats(input logic [2:0] hb);
        logic [3:0] n;
        case (hb)
            3'd2, 3'd3: n = 4'd3;
            3'd4, 3'd5: n = 4'd7;
            3'd6, 3'd7: n = 4'd15;
            default:    n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic vec_t onehot(input idx_t idx);
        vec_t v;
        v      = {NUM_MST{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic idx_t rr_pick(input vec_t req, input idx_t ptr);
        idx_t  pick;
        logic  hit;
        cand_t cand;
        pick = DEF_IDX;
        hit  = 1'b0;
        for (int i = 1; i <= NUM_MST; i++) begin
            cand = cand_t'(ptr) + cand_t'(i);
            cand = (cand >= cand_t'(NUM_MST)) ? cand - cand_t'(NUM_MST) : cand;
            pick = (!hit && req[cand[IDXW-1:0]]) ? cand[IDXW-1:0] : pick;
            hit  = hit | req[cand[IDXW-1:0]];
        end
        return pick;
    endfunction

    state_t     state_q, state_d;
    idx_t       gidx_q, gidx_d;
    vec_t       grant_q;
    idx_t       ptr_q, ptr_d;
    logic       lock_q, lock_d;
    idx_t       master_q, master_d;
    logic       mastlock_q, mastlock_d;
    logic [3:0] beats_left_q, beats_left_d;
    logic       undef_q, undef_d;

    logic       owner_req_s;
    logic       ap_ev_s;
    logic       ap_s;
    logic       force_s;
    logic       handover_s;
    logic       any_req_s;
    vec_t       req_eff_s;
    idx_t       win_s;

    assign owner_req_s = bus.hbusreq_i[master_q];
    assign handover_s  = bus.hready_i && (gidx_q != master_q);

`ifdef AIDC_LITE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef logic [TW-1:0] ten_t;

    ten_t tenure_q, tenure_d;
    logic tmo_s;
    vec_t others_req_s;

    // Tenure of an undefined-length INCR owner; restarts whenever ownership moves.
    always_comb begin
        if (handover_s || !undef_q) begin
            tenure_d = ten_t'(0);
        end else if (tenure_q != ten_t'(TIMEOUT)) begin
            tenure_d = tenure_q + ten_t'(1);
        end else begin
            tenure_d = tenure_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tenure_q <= ten_t'(0);
        end else begin
            tenure_q <= tenure_d;
        end
    end

    assign tmo_s        = (tenure_q == ten_t'(TIMEOUT));
    assign others_req_s = bus.hbusreq_i & ~onehot(master_q);
    assign force_s      = bus.hready_i && tmo_s && !mastlock_q &&
                          (bus.htrans_i != HT_BUSY) && (|others_req_s);
    assign req_eff_s    = force_s ? others_req_s : bus.hbusreq_i;
`else
    assign force_s   = 1'b0;
    assign req_eff_s = bus.hbusreq_i;
`endif

    // Arbitration point: bus-side events gated by hready and an active lock.
    always_comb begin
        ap_ev_s = 1'b0;
        case (bus.htrans_i)
            HT_IDLE:   ap_ev_s = 1'b1;
            HT_NONSEQ: ap_ev_s = (bus.hburst_i == HB_SINGLE) || (undef_q && !owner_req_s);
            HT_SEQ:    ap_ev_s = (beats_left_q == 4'd1) || (undef_q && !owner_req_s);
            HT_BUSY:   ap_ev_s = 1'b0;
            default:   ap_ev_s = 1'b0;
        endcase
        ap_s = (bus.hready_i && ap_ev_s && !(mastlock_q && bus.hlock_i[master_q])) || force_s;
    end

    assign any_req_s = |req_eff_s;
    assign win_s     = rr_pick(req_eff_s, ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (ap_s && any_req_s) ? S_GRANT : S_IDLE;
            S_GRANT: state_d = bus.hready_i ? S_OWN : S_GRANT;
            S_OWN: begin
                if (ap_s && !any_req_s) begin
                    state_d = S_IDLE;
                end else if (ap_s && (win_s != gidx_q)) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_OWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant decision; no re-arbitration while a handover is still outstanding.
    always_comb begin
        gidx_d = gidx_q;
        ptr_d  = ptr_q;
        lock_d = lock_q;
        if (ap_s && (state_q != S_GRANT)) begin
            if (any_req_s) begin
                gidx_d = win_s;
                ptr_d  = win_s;
                lock_d = bus.hlock_i[win_s];
            end else begin
                gidx_d = DEF_IDX;
                ptr_d  = DEF_IDX;
                lock_d = 1'b0;
            end
        end else begin
            gidx_d = gidx_q;
        end
    end

    always_comb begin
        if (bus.hready_i) begin
            master_d   = gidx_q;
            mastlock_d = lock_q;
        end else begin
            master_d   = master_q;
            mastlock_d = mastlock_q;
        end
    end

    // Beat tracking; undef is cleared on ownership change so a stale flag cannot open an AP.
    always_comb begin
        beats_left_d = beats_left_q;
        undef_d      = undef_q;
        if (bus.hready_i) begin
            case (bus.htrans_i)
                HT_NONSEQ: begin
                    beats_left_d = burst_beats(bus.hburst_i);
                    undef_d      = (bus.hburst_i == HB_INCR);
                end
                HT_SEQ:  beats_left_d = (beats_left_q == 4'd0) ? 4'd0 : beats_left_q - 4'd1;
                default: beats_left_d = beats_left_q;
            endcase
            if (handover_s) begin
                undef_d = 1'b0;
            end else begin
                undef_d = undef_d;
            end
        end else begin
            beats_left_d = beats_left_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gidx_q       <= DEF_IDX;
            grant_q      <= DEF_OH;
            ptr_q        <= DEF_IDX;
            lock_q       <= 1'b0;
            master_q     <= DEF_IDX;
            mastlock_q   <= 1'b0;
            beats_left_q <= 4'd0;
            undef_q      <= 1'b0;
        end else begin
            gidx_q       <= gidx_d;
            grant_q      <= onehot(gidx_d);
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            master_q     <= master_d;
            mastlock_q   <= mastlock_d;
            beats_left_q <= beats_left_d;
            undef_q      <= undef_d;
        end
    end

    assign bus.hgrant_o    = grant_q;
    assign bus.hmaster_o   = master_q;
    assign bus.hmastlock_o = mastlock_q;

endmodule

// File: tb/tb_aidc_lite_ahb_arbiter.sv
// Directed bench for aidc_lite_ahb_arbiter: reset, SINGLE rotation, fixed burst, lock, INCR hold, reset mid-burst.
module tb_aidc_lite_ahb_arbiter;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    aidc_lite_ahb_arbiter_if #(.NUM_MST(3)) bus_if ();

    aidc_lite_ahb_arbiter #(.NUM_MST(3), .DEFAULT_MST(0), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] req, input logic [2:0] lck, input logic [1:0] tr,
                        input logic [2:0] hb, input logic rdy);
        bus_if.hbusreq_i = req;
        bus_if.hlock_i   = lck;
        bus_if.htrans_i  = tr;
        bus_if.hburst_i  = hb;
        bus_if.hready_i  = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rst_grant", bus_if.hgrant_o, 3'b001);
        chk("rst_master", bus_if.hmaster_o, 2'd0);
        chk("rst_mastlock", bus_if.hmastlock_o, 1'b0);
        chk("rst_state", dut.state_q, 2'd0);
        chk("rst_beats", dut.beats_left_q, 4'd0);
        chk("rst_ptr", dut.ptr_q, 2'd0);
        rst = 1'b0;
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("idle_grant", bus_if.hgrant_o, 3'b001);

        // M1 and M2 alternate on SINGLE transfers
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rr_g1", bus_if.hgrant_o, 3'b010);
        chk("rr_m0_held", bus_if.hmaster_o, 2'd0);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rr_m1", bus_if.hmaster_o, 2'd1);
        step(3'b110, 3'b000, NONSEQ, SINGLE, 1'b1);
        chk("rr_g2", bus_if.hgrant_o, 3'b100);
        chk("rr_m1_held", bus_if.hmaster_o, 2'd1);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rr_m2", bus_if.hmaster_o, 2'd2);
        step(3'b110, 3'b000, NONSEQ, SINGLE, 1'b1);
        chk("rr_g1b", bus_if.hgrant_o, 3'b010);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rr_m1b", bus_if.hmaster_o, 2'd1);
        step(3'b110, 3'b000, NONSEQ, SINGLE, 1'b1);
        chk("rr_g2b", bus_if.hgrant_o, 3'b100);
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("rr_m2b", bus_if.hmaster_o, 2'd2);
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("park_grant", bus_if.hgrant_o, 3'b001);
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("park_master", bus_if.hmaster_o, 2'd0);
        chk("park_state", dut.state_q, 2'd0);

        // M1 INCR8 with waits; M2 requests at beat 2, M1 drops its request at beat 3
        step(3'b010, 3'b000, IDLE, SINGLE, 1'b1);
        chk("b8_grant", bus_if.hgrant_o, 3'b010);
        step(3'b010, 3'b000, IDLE, SINGLE, 1'b1);
        chk("b8_master", bus_if.hmaster_o, 2'd1);
        step(3'b010, 3'b000, NONSEQ, INCR8, 1'b1);
        chk("b8_load", dut.beats_left_q, 4'd7);
        step(3'b110, 3'b000, SEQ, INCR8, 1'b1);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b1);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b0);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b0);
        chk("b8_wait_grant", bus_if.hgrant_o, 3'b010);
        chk("b8_wait_beats", dut.beats_left_q, 4'd5);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b1);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b1);
        step(3'b100, 3'b000, SEQ, INCR8, 1'b1);
        step(3'b100, 3'b100, SEQ, INCR8, 1'b1);
        chk("b8_seq6_grant", bus_if.hgrant_o, 3'b010);
        chk("b8_seq6_beats", dut.beats_left_q, 4'd1);
        step(3'b100, 3'b100, SEQ, INCR8, 1'b0);
        chk("b8_ap_wait", bus_if.hgrant_o, 3'b010);
        step(3'b100, 3'b100, SEQ, INCR8, 1'b1);
        chk("b8_handoff", bus_if.hgrant_o, 3'b100);
        chk("b8_done", dut.beats_left_q, 4'd0);

        // M2 locked over two INCR4 bursts while M1 requests
        step(3'b110, 3'b100, IDLE, SINGLE, 1'b1);
        chk("lk_master", bus_if.hmaster_o, 2'd2);
        chk("lk_mastlock", bus_if.hmastlock_o, 1'b1);
        for (int b = 0; b < 2; b++) begin
            step(3'b110, 3'b100, NONSEQ, INCR4, 1'b1);
            for (int s = 0; s < 3; s++) begin
                step(3'b110, 3'b100, SEQ, INCR4, 1'b1);
            end
            chk("lk_burst_grant", bus_if.hgrant_o, 3'b100);
            chk("lk_burst_mastlock", bus_if.hmastlock_o, 1'b1);
        end
        step(3'b110, 3'b100, IDLE, SINGLE, 1'b1);
        chk("lk_idle_held", bus_if.hgrant_o, 3'b100);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("lk_release", bus_if.hgrant_o, 3'b010);
        chk("lk_release_ml", bus_if.hmastlock_o, 1'b1);
        step(3'b110, 3'b000, IDLE, SINGLE, 1'b1);
        chk("lk_m1", bus_if.hmaster_o, 2'd1);
        chk("lk_ml_clear", bus_if.hmastlock_o, 1'b0);

        // M0 undefined-length INCR holds the bus until it drops hbusreq
        step(3'b011, 3'b000, IDLE, SINGLE, 1'b1);
        chk("un_grant", bus_if.hgrant_o, 3'b001);
        step(3'b011, 3'b000, IDLE, SINGLE, 1'b1);
        chk("un_master", bus_if.hmaster_o, 2'd0);
        step(3'b011, 3'b000, NONSEQ, INCR, 1'b1);
        chk("un_flag", dut.undef_q, 1'b1);
        for (int s = 0; s < 20; s++) begin
            step(3'b011, 3'b000, SEQ, INCR, 1'b1);
        end
        chk("un_hold", bus_if.hgrant_o, 3'b001);
        step(3'b010, 3'b000, SEQ, INCR, 1'b1);
        chk("un_drop", bus_if.hgrant_o, 3'b010);
        step(3'b010, 3'b000, IDLE, SINGLE, 1'b1);
        chk("un_m1", bus_if.hmaster_o, 2'd1);

        // Reset during beat 5 of an M1 INCR16
        step(3'b010, 3'b000, NONSEQ, INCR16, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(3'b010, 3'b000, SEQ, INCR16, 1'b1);
        end
        chk("r16_beats", dut.beats_left_q, 4'd12);
        rst = 1'b1;
        step(3'b010, 3'b000, SEQ, INCR16, 1'b1);
        chk("r16_grant", bus_if.hgrant_o, 3'b001);
        chk("r16_master", bus_if.hmaster_o, 2'd0);
        chk("r16_beats0", dut.beats_left_q, 4'd0);
        chk("r16_state", dut.state_q, 2'd0);
        chk("r16_ptr", dut.ptr_q, 2'd0);
        rst = 1'b0;
        step(3'b000, 3'b000, IDLE, SINGLE, 1'b1);
        chk("post_rst_grant", bus_if.hgrant_o, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
